// File: rtl/ledg_pkg.sv
// Shared types and constants for the green-LED PIO write arbiter and its siblings.
package ledg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ledg_state_e;

    localparam int          LEDG_W        = 9;
    localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/ledg_write_arbiter_if.sv
// Requester + Avalon-MM PIO signal bundle; master = arbiter side, slave = requesters/PIO side.
interface ledg_write_arbiter_if
    import ledg_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = LEDG_W
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*DATA_W-1:0] req_mask;
    logic [NUM_REQ-1:0]        ack;
    logic                      busy;
    logic [ID_W-1:0]           grant_id;
    logic [1:0]                avm_address;
    logic                      avm_chipselect;
    logic                      avm_write_n;
    logic [31:0]               avm_writedata;
    logic [31:0]               avm_readdata;

    modport master (
        input  req, req_data, req_mask, avm_readdata,
        output ack, busy, grant_id, avm_address, avm_chipselect, avm_write_n, avm_writedata
    );

    modport slave (
        output req, req_data, req_mask, avm_readdata,
        input  ack, busy, grant_id, avm_address, avm_chipselect, avm_write_n, avm_writedata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from ptr+1, wrapping.
// Zero latency, no backpressure; reusable by the other PIO arbiters.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               vld_o
);
    localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

    logic [ID_W:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            // ptr+i stays below 2*NUM_REQ, so one conditional subtract is the modulo
            cand = {1'b0, ptr_i} + (ID_W+1)'(i);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req_i[cand[ID_W-1:0]]) begin
                found                  = 1'b1;
                idx_o                  = cand[ID_W-1:0];
                gnt_o[cand[ID_W-1:0]]  = 1'b1;
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/ledg_write_arbiter.sv
// Round-robin read-modify-write arbiter sharing the green-LED PIO register among NUM_REQ requesters.
// Latency: grant in IDLE, PIO read +1, write +2, ack +3; requesters hold req until their ack pulse.
module ledg_write_arbiter
    import ledg_pkg::*;
#(
    parameter int         NUM_REQ  = 4,
    parameter int         DATA_W   = LEDG_W,
    parameter logic [1:0] PIO_ADDR = PIO_DATA_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    ledg_write_arbiter_if.master bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    ledg_state_e          state_q;
    logic [ID_W-1:0]      ptr_q;
    logic [ID_W-1:0]      grant_id_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [DATA_W-1:0]    data_q;
    logic [DATA_W-1:0]    mask_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 busy_q;
    logic                 cs_q;
    logic                 write_n_q;

    logic [NUM_REQ-1:0]   grant_oh_d;
    logic [ID_W-1:0]      grant_idx_d;
    logic                 grant_vld_d;
    logic [DATA_W-1:0]    wdata_d;
    logic                 unused_rdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (grant_oh_d),
        .idx_o (grant_idx_d),
        .vld_o (grant_vld_d)
    );

    // The read shadow is folded straight into the merged write word at the end of READ.
    assign wdata_d      = (bus.avm_readdata[DATA_W-1:0] & ~mask_q) | (data_q & mask_q);
    assign unused_rdata = ^bus.avm_readdata[31:DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= ID_W'(NUM_REQ-1);
            grant_id_q <= '0;
            gnt_q      <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            wdata_q    <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            cs_q       <= 1'b0;
            write_n_q  <= 1'b1;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld_d) begin
                        grant_id_q <= grant_idx_d;
                        gnt_q      <= grant_oh_d;
                        data_q     <= bus.req_data[grant_idx_d*DATA_W +: DATA_W];
                        mask_q     <= bus.req_mask[grant_idx_d*DATA_W +: DATA_W];
                        busy_q     <= 1'b1;
                        cs_q       <= 1'b1;
                        write_n_q  <= 1'b1;
                        state_q    <= ST_READ;
                    end
                end
                ST_READ: begin
                    wdata_q   <= wdata_d;
                    write_n_q <= 1'b0;
                    state_q   <= ST_WRITE;
                end
                ST_WRITE: begin
                    cs_q      <= 1'b0;
                    write_n_q <= 1'b1;
                    wdata_q   <= '0;
                    ack_q     <= gnt_q;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    // Pointer moves only now, so a requester still holding req gets no head start.
                    ptr_q   <= grant_id_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack            = ack_q;
    assign bus.busy           = busy_q;
    assign bus.grant_id       = grant_id_q;
    assign bus.avm_address    = PIO_ADDR;
    assign bus.avm_chipselect = cs_q;
    assign bus.avm_write_n    = write_n_q;
    assign bus.avm_writedata  = {{(32-DATA_W){1'b0}}, wdata_q};

endmodule

// File: tb/tb_ledg_write_arbiter.sv
// Scenario bench for ledg_write_arbiter: expected writes/acks queued at stimulus time, compared on output.
module tb_ledg_write_arbiter;
    import ledg_pkg::*;

    localparam int N = 4;
    localparam int W = LEDG_W;

    typedef struct {
        int          id;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ledg_write_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    ledg_write_arbiter #(
        .NUM_REQ  (N),
        .DATA_W   (W),
        .PIO_ADDR (PIO_DATA_ADDR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cur_id = 0;

    task automatic set_rq(input int i, input logic [W-1:0] d, input logic [W-1:0] m);
        bus.req_data[i*W +: W] = d;
        bus.req_mask[i*W +: W] = m;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus.req          = '0;
        bus.req_data     = '0;
        bus.req_mask     = '0;
        bus.avm_readdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.avm_chipselect, bus.avm_write_n, bus.busy, bus.ack} !== 7'b0100000) begin
            errors++;
            $display("FAIL reset_ctrl: cs/wn/busy/ack=%b expected 0100000",
                     {bus.avm_chipselect, bus.avm_write_n, bus.busy, bus.ack});
        end
        checks++;
        if (bus.grant_id !== 2'd0 || bus.avm_address !== PIO_DATA_ADDR || bus.avm_writedata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: grant_id=%0d addr=%0d wdata=%h expected 0/0/0",
                     bus.grant_id, bus.avm_address, bus.avm_writedata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        set_rq(0, 9'h1FF, 9'h1FF);
        bus.avm_readdata = 32'h0;
        bus.req          = 4'b0001;
        sb.push_back('{id: 0, wdata: 32'h1FF});
        @(negedge clk);
        checks++;
        if ({bus.avm_chipselect, bus.avm_write_n, bus.busy, bus.ack} !== 7'b1110000
            || bus.avm_address !== PIO_DATA_ADDR) begin
            errors++;
            $display("FAIL single_read: cs/wn/busy/ack=%b addr=%0d expected 1110000 addr 0",
                     {bus.avm_chipselect, bus.avm_write_n, bus.busy, bus.ack}, bus.avm_address);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({bus.avm_chipselect, bus.avm_write_n, bus.busy, bus.ack} !== 7'b1010000
            || bus.avm_writedata !== e.wdata) begin
            errors++;
            $display("FAIL single_write: cs/wn/busy/ack=%b wdata=%h expected 1010000 wdata %h",
                     {bus.avm_chipselect, bus.avm_write_n, bus.busy, bus.ack}, bus.avm_writedata, e.wdata);
        end
        @(negedge clk);
        checks++;
        if ({bus.avm_chipselect, bus.avm_write_n, bus.busy, bus.ack} !== 7'b0110001 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL single_ack: cs/wn/busy/ack=%b grant=%0d expected 0110001 grant 0",
                     {bus.avm_chipselect, bus.avm_write_n, bus.busy, bus.ack}, bus.grant_id);
        end
        bus.req = '0;
        @(negedge clk);
        checks++;
        if ({bus.avm_chipselect, bus.avm_write_n, bus.busy, bus.ack} !== 7'b0100000) begin
            errors++;
            $display("FAIL single_idle: cs/wn/busy/ack=%b expected 0100000",
                     {bus.avm_chipselect, bus.avm_write_n, bus.busy, bus.ack});
        end
    endtask

    task automatic test_mask_merge();
        int acks = 0;
        @(negedge clk);
        set_rq(1, 9'h003, 9'h00F);
        bus.avm_readdata = 32'h0F0;
        bus.req          = 4'b0010;
        sb.push_back('{id: 1, wdata: 32'h0F3});
        for (int c = 0; c < 10 && acks < 1; c++) begin
            @(negedge clk);
            if (bus.avm_chipselect && !bus.avm_write_n) begin
                e = sb.pop_front();
                cur_id = e.id;
                checks++;
                if (bus.avm_writedata !== e.wdata || bus.grant_id !== 2'(e.id)) begin
                    errors++;
                    $display("FAIL merge_write: wdata=%h grant=%0d expected %h grant %0d",
                             bus.avm_writedata, bus.grant_id, e.wdata, e.id);
                end
            end
            if (bus.ack !== '0) begin
                acks++;
                checks++;
                if (bus.ack !== 4'(1 << cur_id)) begin
                    errors++;
                    $display("FAIL merge_ack: ack=%b expected one-hot %0d", bus.ack, cur_id);
                end
                bus.req = '0;
            end
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL merge_timeout: acks=%0d expected 1", acks);
        end
    endtask

    task automatic test_fairness();
        int acks    = 0;
        int last_wr = -1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_rq(i, W'(9'h010 + i), 9'h1FF);
        bus.avm_readdata = 32'h0;
        bus.req          = 4'b1111;
        for (int k = 0; k < 5; k++) sb.push_back('{id: k % N, wdata: 32'(9'h010 + (k % N))});
        for (int c = 0; c < 40 && acks < 5; c++) begin
            @(negedge clk);
            if (bus.avm_chipselect && !bus.avm_write_n) begin
                e = sb.pop_front();
                cur_id = e.id;
                checks++;
                if (bus.avm_writedata !== e.wdata || bus.grant_id !== 2'(e.id)) begin
                    errors++;
                    $display("FAIL fair_order: wdata=%h grant=%0d expected %h grant %0d",
                             bus.avm_writedata, bus.grant_id, e.wdata, e.id);
                end
                if (last_wr >= 0) begin
                    checks++;
                    if (c - last_wr != 4) begin
                        errors++;
                        $display("FAIL fair_spacing: %0d cycles between writes expected 4", c - last_wr);
                    end
                end
                last_wr = c;
            end
            if (bus.ack !== '0) begin
                acks++;
                checks++;
                if (bus.ack !== 4'(1 << cur_id)) begin
                    errors++;
                    $display("FAIL fair_ack: ack=%b expected one-hot %0d", bus.ack, cur_id);
                end
                if (acks == 5) bus.req = '0;
            end
        end
        checks++;
        if (acks != 5) begin
            errors++;
            $display("FAIL fair_timeout: acks=%0d expected 5", acks);
        end
    endtask

    task automatic test_mask_zero();
        int acks = 0;
        @(negedge clk);
        set_rq(2, 9'h0AA, 9'h000);
        bus.avm_readdata = 32'h155;
        bus.req          = 4'b0100;
        sb.push_back('{id: 2, wdata: 32'h155});
        for (int c = 0; c < 10 && acks < 1; c++) begin
            @(negedge clk);
            if (bus.avm_chipselect && !bus.avm_write_n) begin
                e = sb.pop_front();
                cur_id = e.id;
                checks++;
                if (bus.avm_writedata !== e.wdata || bus.grant_id !== 2'(e.id)) begin
                    errors++;
                    $display("FAIL mask0_write: wdata=%h grant=%0d expected %h grant %0d",
                             bus.avm_writedata, bus.grant_id, e.wdata, e.id);
                end
            end
            if (bus.ack !== '0) begin
                acks++;
                checks++;
                if (bus.ack !== 4'(1 << cur_id)) begin
                    errors++;
                    $display("FAIL mask0_ack: ack=%b expected one-hot %0d", bus.ack, cur_id);
                end
                bus.req = '0;
            end
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL mask0_timeout: acks=%0d expected 1", acks);
        end
    endtask

    task automatic test_data_sampling();
        int acks = 0;
        @(negedge clk);
        set_rq(0, 9'h0AA, 9'h1FF);
        bus.avm_readdata = 32'h0;
        bus.req          = 4'b0001;
        sb.push_back('{id: 0, wdata: 32'h0AA});
        for (int c = 0; c < 10 && acks < 1; c++) begin
            @(negedge clk);
            if (bus.avm_chipselect && bus.avm_write_n) set_rq(0, 9'h055, 9'h1FF);
            if (bus.avm_chipselect && !bus.avm_write_n) begin
                e = sb.pop_front();
                cur_id = e.id;
                checks++;
                if (bus.avm_writedata !== e.wdata) begin
                    errors++;
                    $display("FAIL sample_write: wdata=%h expected %h", bus.avm_writedata, e.wdata);
                end
            end
            if (bus.ack !== '0) begin
                acks++;
                checks++;
                if (bus.ack !== 4'(1 << cur_id)) begin
                    errors++;
                    $display("FAIL sample_ack: ack=%b expected one-hot %0d", bus.ack, cur_id);
                end
                bus.req = '0;
            end
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL sample_timeout: acks=%0d expected 1", acks);
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        @(negedge clk);
        set_rq(0, 9'h021, 9'h1FF);
        set_rq(1, 9'h142, 9'h1FF);
        bus.avm_readdata = 32'h0;
        bus.req          = 4'b0010;
        repeat (2) @(negedge clk);
        checks++;
        if (!(bus.avm_chipselect && !bus.avm_write_n) || bus.avm_writedata !== 32'h142) begin
            errors++;
            $display("FAIL rstmid_prewrite: cs=%b wn=%b wdata=%h expected write of 142",
                     bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.avm_chipselect, bus.avm_write_n, bus.busy, bus.ack} !== 7'b0100000
            || bus.grant_id !== 2'd0 || bus.avm_writedata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async: cs/wn/busy/ack=%b grant=%0d wdata=%h expected 0100000/0/0",
                     {bus.avm_chipselect, bus.avm_write_n, bus.busy, bus.ack}, bus.grant_id, bus.avm_writedata);
        end
        bus.req = 4'b0011;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.ack !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_hold: ack=%b busy=%b expected 0/0", bus.ack, bus.busy);
        end
        reset = 1'b0;
        sb.push_back('{id: 0, wdata: 32'h021});
        sb.push_back('{id: 1, wdata: 32'h142});
        for (int c = 0; c < 20 && acks < 2; c++) begin
            @(negedge clk);
            if (bus.avm_chipselect && !bus.avm_write_n) begin
                e = sb.pop_front();
                cur_id = e.id;
                checks++;
                if (bus.avm_writedata !== e.wdata || bus.grant_id !== 2'(e.id)) begin
                    errors++;
                    $display("FAIL rstmid_order: wdata=%h grant=%0d expected %h grant %0d",
                             bus.avm_writedata, bus.grant_id, e.wdata, e.id);
                end
            end
            if (bus.ack !== '0) begin
                acks++;
                checks++;
                if (bus.ack !== 4'(1 << cur_id)) begin
                    errors++;
                    $display("FAIL rstmid_ack: ack=%b expected one-hot %0d", bus.ack, cur_id);
                end
                bus.req[cur_id] = 1'b0;
            end
        end
        checks++;
        if (acks != 2) begin
            errors++;
            $display("FAIL rstmid_timeout: acks=%0d expected 2", acks);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mask_merge();
        test_fairness();
        test_mask_zero();
        test_data_sampling();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected entries left unconsumed", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/ledg_write_arbiter.md
Name: ledg_write_arbiter

Overview:
- Shares the single green-LED PIO slave (9-bit output register at address 0) between NUM_REQ independent requesters, e.g. game-state logic, score display and a heartbeat blinker.
- Each requester posts a 9-bit value plus a 9-bit bit-mask. The block grants requesters round-robin and performs an Avalon-MM read-modify-write on the PIO, so each requester only changes the LED bits it owns.
- Sits between the requesters and the PIO slave port, in the same clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 9, LED register width (bits of the PIO data register).
- PIO_ADDR, 0, PIO register address used for both the read and the write.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held high until the matching ack.
- req_data  in  NUM_REQ*DATA_W  packed new LED values; requester i occupies bits [i*DATA_W +: DATA_W].
- req_mask  in  NUM_REQ*DATA_W  packed bit-enables; 1 = replace this bit.
- ack  out  NUM_REQ  one-cycle pulse to the requester whose write has completed.
- busy  out  1  high while a transaction is in progress (any state except IDLE).
- grant_id  out  clog2(NUM_REQ)  index of the current or most recent grantee.
- avm_address  out  2  PIO address.
- avm_chipselect  out  1  PIO chipselect.
- avm_write_n  out  1  PIO write strobe, active-low.
- avm_writedata  out  32  PIO write data, zero-extended above DATA_W.
- avm_readdata  in  32  PIO read data. Combinational, zero wait states; only bits [DATA_W-1:0] are used.

Behaviour:
- Reset state (asynchronous, while reset=1):
  - FSM=IDLE; ack=0; busy=0; grant_id=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - avm_chipselect=0; avm_write_n=1; avm_address=PIO_ADDR; avm_writedata=0.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - Register grant_id and latch that requester's data and mask.
  - Go to READ. All PIO outputs stay inactive this cycle.
- READ (1 cycle):
  - Drive avm_chipselect=1, avm_write_n=1, avm_address=PIO_ADDR.
  - Capture avm_readdata[DATA_W-1:0] into a shadow register at the clock edge.
  - Go to WRITE.
- WRITE (1 cycle):
  - Drive avm_chipselect=1, avm_write_n=0, avm_address=PIO_ADDR.
  - avm_writedata = (shadow & ~mask) | (data & mask), zero-extended to 32 bits.
  - Go to DONE.
- DONE (1 cycle):
  - ack[grant_id]=1; set pointer=grant_id; PIO outputs inactive.
  - Return to IDLE.
- Latency and throughput:
  - req seen in IDLE at cycle N -> read at N+1, write at N+2, ack at N+3.
  - Minimum 4 cycles per transaction; back-to-back grants alternate fairly.
- Fairness: with all requesters permanently asserted, the grant order is 0,1,2,3,0,...
- req_data and req_mask are sampled only in IDLE at grant time. Later changes do not affect the transaction in flight.
- A req bit dropped before its ack does not abort a transaction already in flight; the ack is still issued.
- If a requester keeps req high after its ack, the DONE->IDLE cycle gives it no preference; it is re-arbitrated against the others normally.
- mask=0: the write is still performed and writes back the value read, unchanged. mask all-ones is a plain overwrite.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and no ack is issued. If reset hits during WRITE, that PIO write may or may not take effect; requesters must re-request after reset.
- busy=1 in READ, WRITE and DONE.

Decomposition:
- Shared package ledg_pkg holds:
  - the FSM state enum;
  - the LEDG_W=9 constant;
  - the PIO data register address constant (0).
- One natural sub-module, rr_arbiter: a combinational round-robin priority pick taking req and the pointer, producing a one-hot grant and an index. It is reusable by other PIO arbiters (red LEDs, HEX displays).

Test Plan:
- Reset, then req=0001, data0=0x1FF, mask0=0x1FF, PIO readback 0x000 -> read at cycle 1, write 0x1FF at cycle 2, ack[0] at cycle 3, busy high for cycles 1-3.
- PIO holds 0x0F0; req1 with data=0x003, mask=0x00F -> written value 0x0F3 and ack[1].
- req=1111 held continuously -> grants 0,1,2,3,0 at 4-cycle spacing, one ack pulse each.
- req2 with mask=0x000 and PIO holding 0x155 -> write of 0x155 still issued, ack[2] pulses.
- Change data0 from 0x0AA to 0x055 during READ -> written value uses 0x0AA.
- Assert reset during WRITE -> all outputs return to reset values asynchronously, no ack; after release, req0 is served first.
